// File: rtl/parity_pkg.sv
// ============================================================================
// Module      : parity_pkg
// Description : Shared state encoding and parity-sense constants for the
//               serial parity-frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage : parity_pkg

`default_nettype wire

// File: rtl/parity_acc.sv
// ============================================================================
// Module      : parity_acc
// Description : One-bit running-XOR accumulator with synchronous clear and
//               enable; clear takes priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    logic r_q;
    logic w_next;

    assign w_next = r_q ^ d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (clr) begin
            r_q <= 1'b0;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule : parity_acc

`default_nettype wire

// File: rtl/parity_frame_rx.sv
// ============================================================================
// Module      : parity_frame_rx
// Description : Serial LSB-first frame receiver: assembles WIDTH data bits,
//               checks the trailing parity bit and strobes done for a cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             parity_err,
    output logic             done,
    output logic             busy
);

    localparam int             CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic           c_SENSE = (ODD != 0) ? PAR_ODD : PAR_EVEN;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic             r_done;
    logic             r_busy;

    logic             w_acc_clr;
    logic             w_data_take;
    logic             w_par_take;
    logic             w_par;
    logic             w_err;

    parity_acc u_parity_acc (
        .clk (clk),
        .rst (rst),
        .clr (w_acc_clr),
        .en  (w_data_take),
        .d   (bit_in),
        .q   (w_par)
    );

    assign w_err = w_par ^ bit_in ^ c_SENSE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_acc_clr    = 1'b0;
        w_data_take  = 1'b0;
        w_par_take   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = DATA;
                    w_acc_clr    = 1'b1;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    w_data_take = 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_next_state = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    w_par_take   = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= (w_next_state == DONE);
            r_busy <= (w_next_state == DATA) || (w_next_state == PARITY);
            if (w_acc_clr) begin
                r_cnt  <= '0;
                r_word <= '0;
            end else if (w_data_take) begin
                r_word[r_cnt] <= bit_in;
                r_cnt         <= r_cnt + CNT_W'(1);
            end
            if (w_par_take) begin
                r_data <= r_word;
                r_err  <= w_err;
            end
        end
    end

    assign data_out   = r_data;
    assign parity_err = r_err;
    assign done       = r_done;
    assign busy       = r_busy;

endmodule : parity_frame_rx

`default_nettype wire
